// File: rtl/rx_hd1080_lock_ctrl.sv
// rtl/rx_hd1080_lock_ctrl.sv - HD-SDI 1080 rx timing-lock controller
// Measures line/frame length from decoded H/V flags and selects live vs fallback video.
module rx_hd1080_lock_ctrl #(
  parameter int PIX_PER_LINE    = 2200,
  parameter int LINES_PER_FRAME = 1125,
  parameter int LOCK_FRAMES     = 4,
  parameter int UNLOCK_FRAMES   = 2,
  parameter int TIMEOUT         = 4400
) (
  input  logic       i_clk,
  input  logic       rst_n,
  input  logic       i_h,
  input  logic       i_v,
  input  logic       i_err_clr,
  output logic       o_locked,
  output logic       o_sel_live,
  output logic [1:0] o_state,
  output logic       o_line_err,
  output logic       o_frame_start,
  output logic [7:0] o_err_cnt
);

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  // The pixel counter must reach both the line length and the loss timeout.
  localparam int CNT_SPAN = (TIMEOUT > PIX_PER_LINE) ? TIMEOUT : PIX_PER_LINE;
  localparam int CNT_BITS = $clog2(CNT_SPAN + 1);
  localparam int PIX_W    = (CNT_BITS > 12) ? CNT_BITS : 12;

  localparam logic [PIX_W-1:0] PIX_LAST  = PIX_W'(PIX_PER_LINE - 1);
  localparam logic [PIX_W-1:0] TOUT_LAST = PIX_W'(TIMEOUT - 1);
  localparam logic [10:0]      LN_LAST   = 11'(LINES_PER_FRAME - 1);
  localparam logic [3:0]       LOCK_N    = 4'(LOCK_FRAMES);
  localparam logic [3:0]       UNLOCK_N  = 4'(UNLOCK_FRAMES);

  logic             h_q1, h_q2, v_q1, v_q2;
  logic [PIX_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [10:0]      ln_cnt_q, ln_cnt_d;
  logic             line_seen_q, line_seen_d;
  logic             bad_seen_q, bad_seen_d;
  state_t           state_q, state_d;
  logic [3:0]       good_cnt_q, good_cnt_d;
  logic [3:0]       bad_cnt_q, bad_cnt_d;
  logic             locked_q, locked_d;
  logic             sel_live_q, sel_live_d;
  logic             line_err_q, line_err_d;
  logic             frame_start_q, frame_start_d;
  logic [7:0]       err_cnt_q, err_cnt_d;

  logic h_rise, v_rise, frame_mark, line_bad, timeout, frame_ok, in_lock;
  logic [3:0] good_inc, bad_inc;

  always_comb begin
    h_rise     = h_q1 & ~h_q2;
    v_rise     = v_q1 & ~v_q2;
    frame_mark = h_rise & v_rise;
    line_bad   = h_rise & line_seen_q & (pix_cnt_q != PIX_LAST);
    timeout    = (pix_cnt_q == TOUT_LAST) & ~h_rise;
    // The line closed by this mark belongs to the frame being judged.
    frame_ok   = (ln_cnt_q == LN_LAST) & ~bad_seen_q & ~line_bad;
    in_lock    = (state_q == ST_LOCKED) | (state_q == ST_HOLD);
    good_inc   = good_cnt_q + 4'd1;
    bad_inc    = bad_cnt_q + 4'd1;
  end

  always_comb begin
    pix_cnt_d = pix_cnt_q;
    if (h_rise)
      pix_cnt_d = '0;
    else if (pix_cnt_q != '1)
      pix_cnt_d = pix_cnt_q + 1'b1;

    ln_cnt_d = ln_cnt_q;
    if (frame_mark)
      ln_cnt_d = '0;
    else if (h_rise && (ln_cnt_q != 11'h7FF))
      ln_cnt_d = ln_cnt_q + 11'd1;

    line_seen_d = line_seen_q;
    if (timeout)
      line_seen_d = 1'b0;
    else if (h_rise)
      line_seen_d = 1'b1;

    bad_seen_d = bad_seen_q;
    if (frame_mark)
      bad_seen_d = 1'b0;
    else if (line_bad)
      bad_seen_d = 1'b1;

    err_cnt_d = err_cnt_q;
    if (i_err_clr)
      err_cnt_d = '0;
    else if (line_bad && in_lock && (err_cnt_q != 8'hFF))
      err_cnt_d = err_cnt_q + 8'd1;
  end

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    bad_cnt_d  = bad_cnt_q;
    if (timeout) begin
      state_d    = ST_SEARCH;
      good_cnt_d = '0;
      bad_cnt_d  = '0;
    end else if (frame_mark) begin
      case (state_q)
        ST_SEARCH: begin
          state_d    = ST_VERIFY;
          good_cnt_d = '0;
          bad_cnt_d  = '0;
        end
        ST_VERIFY: begin
          if (!frame_ok) begin
            good_cnt_d = '0;
          end else if (good_inc == LOCK_N) begin
            state_d    = ST_LOCKED;
            good_cnt_d = '0;
          end else begin
            good_cnt_d = good_inc;
          end
        end
        ST_LOCKED: begin
          if (!frame_ok) begin
            if (UNLOCK_N == 4'd1) begin
              state_d = ST_SEARCH;
            end else begin
              state_d   = ST_HOLD;
              bad_cnt_d = 4'd1;
            end
          end
        end
        ST_HOLD: begin
          if (frame_ok) begin
            state_d   = ST_LOCKED;
            bad_cnt_d = '0;
          end else if (bad_inc == UNLOCK_N) begin
            state_d   = ST_SEARCH;
            bad_cnt_d = '0;
          end else begin
            bad_cnt_d = bad_inc;
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end

    // Lock and source select follow the next state so they switch on the mark itself.
    locked_d      = (state_d == ST_LOCKED) | (state_d == ST_HOLD);
    sel_live_d    = (state_d == ST_LOCKED) | (state_d == ST_HOLD);
    line_err_d    = line_bad;
    frame_start_d = frame_mark;
  end

  always_ff @(posedge i_clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q1          <= 1'b0;
      h_q2          <= 1'b0;
      v_q1          <= 1'b0;
      v_q2          <= 1'b0;
      pix_cnt_q     <= '0;
      ln_cnt_q      <= '0;
      line_seen_q   <= 1'b0;
      bad_seen_q    <= 1'b0;
      state_q       <= ST_SEARCH;
      good_cnt_q    <= '0;
      bad_cnt_q     <= '0;
      locked_q      <= 1'b0;
      sel_live_q    <= 1'b0;
      line_err_q    <= 1'b0;
      frame_start_q <= 1'b0;
      err_cnt_q     <= '0;
    end else begin
      h_q1          <= i_h;
      h_q2          <= h_q1;
      v_q1          <= i_v;
      v_q2          <= v_q1;
      pix_cnt_q     <= pix_cnt_d;
      ln_cnt_q      <= ln_cnt_d;
      line_seen_q   <= line_seen_d;
      bad_seen_q    <= bad_seen_d;
      state_q       <= state_d;
      good_cnt_q    <= good_cnt_d;
      bad_cnt_q     <= bad_cnt_d;
      locked_q      <= locked_d;
      sel_live_q    <= sel_live_d;
      line_err_q    <= line_err_d;
      frame_start_q <= frame_start_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign o_locked      = locked_q;
  assign o_sel_live    = sel_live_q;
  assign o_state       = state_q;
  assign o_line_err    = line_err_q;
  assign o_frame_start = frame_start_q;
  assign o_err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_rx_hd1080_lock_ctrl.sv
// tb/tb_rx_hd1080_lock_ctrl.sv - self-checking bench for rx_hd1080_lock_ctrl
// Scaled-down raster; timestamp-based reference model checked every clock.
module tb_rx_hd1080_lock_ctrl;

  localparam int PIX    = 32;
  localparam int LINES  = 12;
  localparam int TOUT   = 100;
  localparam int LOCKF  = 4;
  localparam int UNLOCKF = 2;
  localparam int HW     = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_h = 1'b0, i_v = 1'b0, i_err_clr = 1'b0;
  logic       o_locked, o_sel_live, o_line_err, o_frame_start;
  logic [1:0] o_state;
  logic [7:0] o_err_cnt;

  always #5 clk = ~clk;

  rx_hd1080_lock_ctrl #(
    .PIX_PER_LINE(PIX), .LINES_PER_FRAME(LINES), .LOCK_FRAMES(LOCKF),
    .UNLOCK_FRAMES(UNLOCKF), .TIMEOUT(TOUT)
  ) dut (
    .i_clk(clk), .rst_n(rst_n), .i_h(i_h), .i_v(i_v), .i_err_clr(i_err_clr),
    .o_locked(o_locked), .o_sel_live(o_sel_live), .o_state(o_state),
    .o_line_err(o_line_err), .o_frame_start(o_frame_start), .o_err_cnt(o_err_cnt)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: edge timestamps, line/frame tallies and the lock rules.
  int edge_n, last_rise, lines_since_mark, m_state, good, badc, errc;
  bit seen_line, frame_bad, hist1, hist2, vh1, vh2;
  int e_state, e_err;
  bit e_lerr, e_fs;

  task automatic model_reset();
    edge_n = 0; last_rise = 0; lines_since_mark = 0;
    m_state = 0; good = 0; badc = 0; errc = 0;
    seen_line = 0; frame_bad = 0; hist1 = 0; hist2 = 0; vh1 = 0; vh2 = 0;
    e_state = 0; e_err = 0; e_lerr = 0; e_fs = 0;
  endtask

  task automatic model_step(input bit h, input bit v, input bit clr);
    bit rise, mark, tout, lbad, fok, was_locked;
    int gap;
    edge_n++;
    rise = hist1 && !hist2;
    mark = rise && vh1 && !vh2;
    gap  = edge_n - last_rise;
    tout = !rise && (gap == TOUT);
    lbad = rise && seen_line && (gap != PIX);
    fok  = (lines_since_mark == LINES - 1) && !frame_bad && !lbad;
    was_locked = (m_state >= 2);
    if (rise) begin
      last_rise = edge_n;
      seen_line = 1;
    end
    if (clr) errc = 0;
    else if (lbad && was_locked && errc < 255) errc++;
    if (mark) frame_bad = 0;
    else if (lbad) frame_bad = 1;
    if (mark) lines_since_mark = 0;
    else if (rise && lines_since_mark < 2047) lines_since_mark++;
    if (tout) begin
      m_state = 0; good = 0; badc = 0; seen_line = 0;
    end else if (mark) begin
      case (m_state)
        0: begin m_state = 1; good = 0; end
        1: begin
          if (!fok) good = 0;
          else if (good + 1 == LOCKF) begin m_state = 2; good = 0; end
          else good++;
        end
        2: if (!fok) begin
          if (UNLOCKF == 1) m_state = 0;
          else begin m_state = 3; badc = 1; end
        end
        default: begin
          if (fok) begin m_state = 2; badc = 0; end
          else if (badc + 1 == UNLOCKF) begin m_state = 0; badc = 0; end
          else badc++;
        end
      endcase
    end
    e_state = m_state; e_err = errc; e_lerr = lbad; e_fs = mark;
    hist2 = hist1; hist1 = h; vh2 = vh1; vh1 = v;
  endtask

  task automatic tick(input bit h, input bit v, input bit clr);
    @(negedge clk);
    i_h = h; i_v = v; i_err_clr = clr;
    @(posedge clk);
    model_step(h, v, clr);
    #1;
    check_eq("state", 32'(o_state), 32'(e_state));
    check_eq("locked", 32'(o_locked), 32'(e_state >= 2));
    check_eq("sel_live", 32'(o_sel_live), 32'(e_state >= 2));
    check_eq("line_err", 32'(o_line_err), 32'(e_lerr));
    check_eq("frame_start", 32'(o_frame_start), 32'(e_fs));
    check_eq("err_cnt", 32'(o_err_cnt), 32'(e_err));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; i_h = 1'b0; i_v = 1'b0; i_err_clr = 1'b0;
    #1;
    check_eq("rst_state", 32'(o_state), 32'd0);
    check_eq("rst_locked", 32'(o_locked), 32'd0);
    check_eq("rst_sel_live", 32'(o_sel_live), 32'd0);
    check_eq("rst_line_err", 32'(o_line_err), 32'd0);
    check_eq("rst_frame_start", 32'(o_frame_start), 32'd0);
    check_eq("rst_err_cnt", 32'(o_err_cnt), 32'd0);
    repeat (3) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
  endtask

  task automatic send_line(input int len, input bit mark, input bit clr1, input bit vglitch);
    for (int j = 0; j < len; j++)
      tick(j < HW, (mark && j < HW) || (vglitch && j == len / 2), clr1 && j == 1);
  endtask

  task automatic send_frame(input int nlines, input int short_idx, input int short_len);
    for (int l = 0; l < nlines; l++)
      send_line((l == short_idx) ? short_len : PIX, l == 0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_state(input string tag, input int st);
    check_eq(tag, 32'(o_state), 32'(st));
    check_eq({tag, "_sel"}, 32'(o_sel_live), 32'(st >= 2));
  endtask

  initial begin
    do_reset();

    // Nominal lock: VERIFY after first mark, LOCKED after the fifth.
    send_frame(LINES, -1, 0);
    chk_state("s1_verify", 1);
    repeat (4) send_frame(LINES, -1, 0);
    chk_state("s1_locked", 2);
    check_eq("s1_err", 32'(o_err_cnt), 32'd0);

    // One short line while locked.
    send_frame(LINES, 3, PIX - 1);
    check_eq("s2_err", 32'(o_err_cnt), 32'd1);
    send_frame(LINES, -1, 0);
    chk_state("s2_hold", 3);
    send_frame(LINES, -1, 0);
    chk_state("s2_relock", 2);

    // Two short frames drop lock at the second mark.
    send_frame(LINES - 1, -1, 0);
    send_frame(LINES - 1, -1, 0);
    chk_state("s3_hold", 3);
    send_frame(LINES, -1, 0);
    chk_state("s3_search", 0);
    check_eq("s3_locked", 32'(o_locked), 32'd0);
    repeat (5) send_frame(LINES, -1, 0);
    chk_state("s3_relock", 2);

    // Signal loss: state falls exactly TOUT clocks after the last h_rise.
    idle(TOUT - PIX + 1);
    chk_state("s4_pre_tout", 2);
    idle(1);
    chk_state("s4_tout", 0);
    check_eq("s4_locked", 32'(o_locked), 32'd0);
    idle(7);
    repeat (5) send_frame(LINES, -1, 0);
    chk_state("s4_relock", 2);

    // Reset mid-frame, then good,good,bad,good x4 in VERIFY.
    send_line(PIX, 1'b1, 1'b0, 1'b0);
    send_line(PIX, 1'b0, 1'b0, 1'b0);
    do_reset();
    send_frame(LINES, -1, 0);
    chk_state("s5_verify", 1);
    send_frame(LINES, -1, 0);
    send_frame(LINES, -1, 0);
    send_frame(LINES, 5, PIX - 1);
    repeat (4) send_frame(LINES, -1, 0);
    chk_state("s5_not_yet", 1);
    send_frame(LINES, -1, 0);
    chk_state("s5_locked", 2);

    // Error counter saturation and clear coincident with a bad line.
    for (int l = 0; l < 301; l++) send_line(PIX - 1, 1'b0, 1'b0, 1'b0);
    check_eq("s6_err_sat", 32'(o_err_cnt), 32'd255);
    chk_state("s6_state", 2);
    send_line(PIX - 1, 1'b0, 1'b1, 1'b0);
    check_eq("s6_err_clr", 32'(o_err_cnt), 32'd0);

    // Randomized rasters against the reference model.
    do_reset();
    for (int f = 0; f < 24; f++) begin
      int nl;
      nl = ($urandom_range(0, 9) < 8) ? LINES : LINES - 1 + 2 * int'($urandom_range(0, 1));
      for (int l = 0; l < nl; l++) begin
        int len;
        len = ($urandom_range(0, 19) == 0) ? PIX - 2 + int'($urandom_range(0, 3)) : PIX;
        send_line(len, l == 0, $urandom_range(0, 29) == 0,
                  (l != 0) && ($urandom_range(0, 19) == 0));
      end
      if ($urandom_range(0, 9) == 0) idle(TOUT - PIX + int'($urandom_range(0, 6)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
